decode_issue_stage: RTL
=======================

# decode_issue_stage

Registered decode/issue stage between instruction fetch and the back end (ROB, reservation station, load/store buffer). It accepts one fetched instruction per cycle and decodes it. Operands are resolved from the register file, from the ROB, or from any of `CDB_CNT` broadcast channels. The decoded entry is held in an output register until the ROB and its target queue can take it. While held, the entry keeps snooping the broadcast channels, so operands that become ready during a stall are captured and never missed.

## Interface
- `XLEN`, 32: data and PC width.
- `ROB_AW`, 4: ROB index width. A source tag is `ROB_AW+1` bits: {pending, rob index}.
- `CDB_CNT`, 2: number of result broadcast channels (ALU, LSB, ...).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable. When low, all state holds.
- `rollback` in 1: flush on misprediction.
- `inst_rdy` in 1: fetch presents a valid instruction.
- `inst`, `inst_pc` in 32/`XLEN`: instruction word and its PC.
- `inst_pred_jump` in 1: predicted-taken flag.
- `dec_ready` out 1: stage accepts `inst` this cycle.
- `reg_rs1`, `reg_rs2` out 5: register-file read addresses, combinational from `inst`.
- `reg_rs1_val`, `reg_rs2_val` in `XLEN`: register-file read data.
- `reg_rs1_tag`, `reg_rs2_tag` in `ROB_AW+1`: register-file rename tags.
- `rob_rs1_pos`, `rob_rs2_pos` out `ROB_AW`: ROB lookup indices, taken from the tags.
- `rob_rs1_ready`, `rob_rs2_ready` in 1: ROB entry for that index holds a result.
- `rob_rs1_val`, `rob_rs2_val` in `XLEN`: ROB result values.
- `cdb_valid` in `CDB_CNT`: per-channel broadcast valid.
- `cdb_rob_pos` in `CDB_CNT*ROB_AW`: per-channel ROB index.
- `cdb_val` in `CDB_CNT*XLEN`: per-channel result value.
- `rob_full`, `rs_full`, `lsb_full` in 1: back-pressure from the ROB, RS and LSB.
- `nxt_rob_pos` in `ROB_AW`: ROB slot to be allocated.
- `issue`, `rs_en`, `lsb_en` out 1: issue strobes.
- `rob_pos` out `ROB_AW`: allocated ROB slot.
- `opcode` out 7, `funct3` out 3, `funct7` out 1 (bit 30), `is_store` out 1, `is_ready` out 1 (store, committable at once), `rd` out 5, `pc` out `XLEN`, `pred_jump` out 1.
- `imm` out `XLEN`: sign-extended immediate.
- `rs1_val`, `rs2_val` out `XLEN`: operand values.
- `rs1_tag`, `rs2_tag` out `ROB_AW+1`: operand tags; 0 means the value is valid.

## Operation
- **Entry register:** one held entry, `valid` plus all decoded fields and operand tags.
- **Accept:** `dec_ready = !valid || fire`, where `fire = valid && !rob_full && !(lsb_en ? lsb_full : rs_full)`.
- **Fetch handshake:** fetch must hold `inst` while `inst_rdy && !dec_ready`.
- **Operand resolve on accept, per source, in priority order:**
  1. Tag pending bit clear: take the register value.
  2. `rob_rsX_ready`: take the ROB value.
  3. Lowest-numbered matching valid CDB channel: take its value.
  4. Otherwise: store the tag with value 0.
- **Immediates and unused operands** follow the RV32I format for each opcode:
  - LOAD, OP-IMM, JALR: rs2 forced to tag 0, value 0.
  - JAL, LUI, AUIPC: rs1 and rs2 forced to tag 0, value 0.
  - STORE and BRANCH: `rd = 0`.
  - STORE: `is_store = is_ready = 1`.
- **Routing:** LOAD/STORE go to `lsb_en`; all other recognised opcodes go to `rs_en`.
- **Unknown opcode:** consumed, never stored (`valid` stays 0), no ROB slot allocated.
- **Wakeup:** every cycle the entry is held, a pending tag matching a valid CDB channel captures that channel's value and its tag clears.
- **Issue:** `issue = rs_en|lsb_en` qualifiers are driven only when `fire`, and `rob_pos = nxt_rob_pos` is sampled in that same cycle. The ROB index is allocated at issue, not at decode.
- **`rollback`:** clears `valid` and suppresses accept and issue in that cycle.
- **`rst`:** same effect as rollback. Outputs then read as:
  - `issue`, `rs_en`, `lsb_en`, `dec_ready`: 0.
  - All fields: 0.
  - Tags: 0.
- **`rdy` low:** no accept, no issue, no wakeup. `dec_ready = 0`.

## Timing
- Decode-to-issue latency: 1 cycle minimum. Accept in cycle N, `issue` in N+1 when unstalled.
- Throughput: 1 instruction per cycle, because the entry is replaced in the same cycle it fires.
- Stall: the entry is held indefinitely, all outputs except `issue`/`*_en` are stable, and wakeup continues.
- Simultaneous fire and accept: the new entry is resolved against the current-cycle CDB, so no broadcast is lost.
- Priority: `rst` > `rollback` > `!rdy` > normal operation.

## Configuration
- Macro: `DECODE_ISSUE_CDB_BYPASS_EN`.
- **Defined:** in a `fire` cycle, `rs1_val`/`rs2_val`/tags combinationally include a same-cycle CDB match, so the issue is not delayed.
- **Undefined:** outputs are purely registered. If a CDB channel matches a pending tag in a would-be `fire` cycle, `fire` is suppressed for that cycle (`dec_ready` follows) and the entry issues the next cycle with the captured value.

## Structure
- **Shared package** `riscv_pkg`: opcode constants (LOAD, STORE, OP, OP_IMM, JAL, JALR, BRANCH, LUI, AUIPC), the decoded-entry struct, and the tag width helper.
- **Sub-module** `operand_resolve`: one instance per source. Combinational priority resolve over reg/ROB/CDB, plus a wakeup comparator used in both accept and hold.

## Test plan
- **Basic ADDI:** `addi x1,x2,-1` (x2 = 5, tag 0), no stall → `issue` next cycle, `rs_en = 1`, `rs1_val = 5`, `imm = 0xFFFFFFFF`, `rs2_tag = 0`.
- **Wakeup while stalled:** load with rs1 tag {1,3}, `lsb_full` high for 4 cycles, CDB ch1 broadcasts pos 3 = 0x100 in cycle 2 → on release, `rs1_tag = 0`, `rs1_val = 0x100`, `lsb_en = 1`.
- **Back-to-back stream:** 3 OP instructions with no stalls → 3 consecutive `issue` pulses, `rob_pos` = successive `nxt_rob_pos` values.
- **Same-cycle broadcast at issue:** pending tag pos 7, CDB ch0 pos 7 = 0x55 in the fire cycle → with the macro, issue that cycle with 0x55; without, issue one cycle later with 0x55.
- **Rollback while stalled:** `rollback` during a held entry → no `issue`, `dec_ready = 1` the next cycle.
- **Store and unknown opcode:** store → `is_ready = is_store = 1`, `rd = 0`; opcode 0x7F → consumed, never issued.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_pkg
// Brief   : RV32I opcode constants, decoded-entry struct and decode helpers
//           shared by the decode/issue stage.
// Rev     : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  rd;
        logic        is_store;
        logic        is_lsb;
        logic [31:0] imm;
    } dec_entry_t;

    function automatic int tag_w(input int rob_aw);
        return rob_aw + 1;
    endfunction

    function automatic logic opc_known(input logic [6:0] opc);
        return opc inside {c_opc_load, c_opc_store, c_opc_op, c_opc_op_imm, c_opc_jal,
                           c_opc_jalr, c_opc_branch, c_opc_lui, c_opc_auipc};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc inside {c_opc_jal, c_opc_lui, c_opc_auipc});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {c_opc_store, c_opc_branch, c_opc_op};
    endfunction

    function automatic dec_entry_t decode(input logic [31:0] inst);
        dec_entry_t d;
        d.opcode   = inst[6:0];
        d.funct3   = inst[14:12];
        d.funct7   = inst[30];
        d.rd       = (inst[6:0] inside {c_opc_store, c_opc_branch}) ? 5'd0 : inst[11:7];
        d.is_store = (inst[6:0] == c_opc_store);
        d.is_lsb   = (inst[6:0] inside {c_opc_load, c_opc_store});
        case (inst[6:0])
            c_opc_load, c_opc_op_imm, c_opc_jalr:
                d.imm = {{20{inst[31]}}, inst[31:20]};
            c_opc_store:
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            c_opc_branch:
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            c_opc_lui, c_opc_auipc:
                d.imm = {inst[31:12], 12'b0};
            c_opc_jal:
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                d.imm = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_resolve.sv
`default_nettype none
// ============================================================================
// Module : operand_resolve
// Brief  : Per-source operand resolve (reg -> ROB -> lowest CDB channel) for a
//          new instruction, plus CDB wakeup of an already-held operand.
// Rev    : 1.0 - initial release
// ============================================================================
module operand_resolve
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROB_AW  = 4,
    parameter int CDB_CNT = 2
) (
    input  logic [ROB_AW:0]         reg_tag,
    input  logic [XLEN-1:0]         reg_val,
    input  logic                    rob_ready,
    input  logic [XLEN-1:0]         rob_val,
    input  logic [CDB_CNT-1:0]      cdb_valid,
    input  logic [CDB_CNT*ROB_AW-1:0] cdb_rob_pos,
    input  logic [CDB_CNT*XLEN-1:0] cdb_val,
    input  logic [ROB_AW:0]         held_tag,
    input  logic [XLEN-1:0]         held_val,
    output logic [ROB_AW:0]         new_tag,
    output logic [XLEN-1:0]         new_val,
    output logic                    wake_hit,
    output logic [ROB_AW:0]         wake_tag,
    output logic [XLEN-1:0]         wake_val
);

    logic [ROB_AW-1:0] w_pos [CDB_CNT];
    logic [XLEN-1:0]   w_val [CDB_CNT];
    logic              w_acc_hit;
    logic [XLEN-1:0]   w_acc_val;
    logic              w_held_hit;
    logic [XLEN-1:0]   w_held_cdb;

    for (genvar g = 0; g < CDB_CNT; g++) begin : g_cdb_unpack
        assign w_pos[g] = cdb_rob_pos[g*ROB_AW +: ROB_AW];
        assign w_val[g] = cdb_val[g*XLEN +: XLEN];
    end

    // Scan from the top channel down so the lowest-numbered match wins.
    always_comb begin
        w_acc_hit  = 1'b0;
        w_acc_val  = '0;
        w_held_hit = 1'b0;
        w_held_cdb = '0;
        for (int i = CDB_CNT - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (w_pos[i] == reg_tag[ROB_AW-1:0])) begin
                w_acc_hit = 1'b1;
                w_acc_val = w_val[i];
            end
            if (cdb_valid[i] && (w_pos[i] == held_tag[ROB_AW-1:0])) begin
                w_held_hit = 1'b1;
                w_held_cdb = w_val[i];
            end
        end
    end

    always_comb begin
        new_tag = '0;
        new_val = '0;
        if (!reg_tag[ROB_AW]) begin
            new_val = reg_val;
        end else if (rob_ready) begin
            new_val = rob_val;
        end else if (w_acc_hit) begin
            new_val = w_acc_val;
        end else begin
            new_tag = reg_tag;
        end
    end

    assign wake_hit = held_tag[ROB_AW] && w_held_hit;
    assign wake_tag = wake_hit ? '0 : held_tag;
    assign wake_val = wake_hit ? w_held_cdb : held_val;

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_issue_stage
// Brief  : Registered RV32I decode/issue stage with operand resolve and CDB
//          wakeup of the held entry. Option macro DECODE_ISSUE_CDB_BYPASS_EN
//          forwards a same-cycle CDB match straight onto the issuing operands.
// Rev    : 1.0 - initial release
// ============================================================================
module decode_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROB_AW  = 4,
    parameter int CDB_CNT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic                      inst_rdy,
    input  logic [31:0]               inst,
    input  logic [XLEN-1:0]           inst_pc,
    input  logic                      inst_pred_jump,
    output logic                      dec_ready,
    output logic [4:0]                reg_rs1,
    output logic [4:0]                reg_rs2,
    input  logic [XLEN-1:0]           reg_rs1_val,
    input  logic [XLEN-1:0]           reg_rs2_val,
    input  logic [ROB_AW:0]           reg_rs1_tag,
    input  logic [ROB_AW:0]           reg_rs2_tag,
    output logic [ROB_AW-1:0]         rob_rs1_pos,
    output logic [ROB_AW-1:0]         rob_rs2_pos,
    input  logic                      rob_rs1_ready,
    input  logic                      rob_rs2_ready,
    input  logic [XLEN-1:0]           rob_rs1_val,
    input  logic [XLEN-1:0]           rob_rs2_val,
    input  logic [CDB_CNT-1:0]        cdb_valid,
    input  logic [CDB_CNT*ROB_AW-1:0] cdb_rob_pos,
    input  logic [CDB_CNT*XLEN-1:0]   cdb_val,
    input  logic                      rob_full,
    input  logic                      rs_full,
    input  logic                      lsb_full,
    input  logic [ROB_AW-1:0]         nxt_rob_pos,
    output logic                      issue,
    output logic                      rs_en,
    output logic                      lsb_en,
    output logic [ROB_AW-1:0]         rob_pos,
    output logic [6:0]                opcode,
    output logic [2:0]                funct3,
    output logic                      funct7,
    output logic                      is_store,
    output logic                      is_ready,
    output logic [4:0]                rd,
    output logic [XLEN-1:0]           pc,
    output logic                      pred_jump,
    output logic [XLEN-1:0]           imm,
    output logic [XLEN-1:0]           rs1_val,
    output logic [XLEN-1:0]           rs2_val,
    output logic [ROB_AW:0]           rs1_tag,
    output logic [ROB_AW:0]           rs2_tag
);

    localparam int TW = tag_w(ROB_AW);

    logic             r_valid;
    dec_entry_t       r_dec;
    logic [XLEN-1:0]  r_pc;
    logic             r_pred_jump;
    logic [XLEN-1:0]  r_rs1_val, r_rs2_val;
    logic [TW-1:0]    r_rs1_tag, r_rs2_tag;

    dec_entry_t       w_dec;
    logic             w_known, w_use_rs1, w_use_rs2;
    logic             w_run, w_fire, w_accept, w_route_full;
    logic [TW-1:0]    w_rs1_new_tag, w_rs2_new_tag, w_rs1_wake_tag, w_rs2_wake_tag;
    logic [XLEN-1:0]  w_rs1_new_val, w_rs2_new_val, w_rs1_wake_val, w_rs2_wake_val;
    logic             w_rs1_wake_hit, w_rs2_wake_hit;

    assign w_dec     = decode(inst);
    assign w_known   = opc_known(inst[6:0]);
    assign w_use_rs1 = uses_rs1(inst[6:0]);
    assign w_use_rs2 = uses_rs2(inst[6:0]);

    assign reg_rs1     = inst[19:15];
    assign reg_rs2     = inst[24:20];
    assign rob_rs1_pos = reg_rs1_tag[ROB_AW-1:0];
    assign rob_rs2_pos = reg_rs2_tag[ROB_AW-1:0];

    operand_resolve #(.XLEN(XLEN), .ROB_AW(ROB_AW), .CDB_CNT(CDB_CNT)) u_rs1 (
        .reg_tag(reg_rs1_tag), .reg_val(reg_rs1_val),
        .rob_ready(rob_rs1_ready), .rob_val(rob_rs1_val),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
        .held_tag(r_rs1_tag), .held_val(r_rs1_val),
        .new_tag(w_rs1_new_tag), .new_val(w_rs1_new_val),
        .wake_hit(w_rs1_wake_hit), .wake_tag(w_rs1_wake_tag), .wake_val(w_rs1_wake_val)
    );

    operand_resolve #(.XLEN(XLEN), .ROB_AW(ROB_AW), .CDB_CNT(CDB_CNT)) u_rs2 (
        .reg_tag(reg_rs2_tag), .reg_val(reg_rs2_val),
        .rob_ready(rob_rs2_ready), .rob_val(rob_rs2_val),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
        .held_tag(r_rs2_tag), .held_val(r_rs2_val),
        .new_tag(w_rs2_new_tag), .new_val(w_rs2_new_val),
        .wake_hit(w_rs2_wake_hit), .wake_tag(w_rs2_wake_tag), .wake_val(w_rs2_wake_val)
    );

    assign w_run        = rdy && !rst && !rollback;
    assign w_route_full = r_dec.is_lsb ? lsb_full : rs_full;

`ifdef DECODE_ISSUE_CDB_BYPASS_EN
    assign w_fire  = w_run && r_valid && !rob_full && !w_route_full;
    assign rs1_val = w_fire ? w_rs1_wake_val : r_rs1_val;
    assign rs2_val = w_fire ? w_rs2_wake_val : r_rs2_val;
    assign rs1_tag = w_fire ? w_rs1_wake_tag : r_rs1_tag;
    assign rs2_tag = w_fire ? w_rs2_wake_tag : r_rs2_tag;
`else
    // A late broadcast holds the entry one cycle so the captured value issues.
    assign w_fire  = w_run && r_valid && !rob_full && !w_route_full
                     && !w_rs1_wake_hit && !w_rs2_wake_hit;
    assign rs1_val = r_rs1_val;
    assign rs2_val = r_rs2_val;
    assign rs1_tag = r_rs1_tag;
    assign rs2_tag = r_rs2_tag;
`endif

    assign dec_ready = w_run && (!r_valid || w_fire);
    assign w_accept  = dec_ready && inst_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_dec       <= '0;
            r_pc        <= '0;
            r_pred_jump <= 1'b0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_rs1_tag   <= '0;
            r_rs2_tag   <= '0;
        end else if (rollback) begin
            r_valid <= 1'b0;
        end else if (rdy) begin
            if (w_accept && w_known) begin
                r_valid     <= 1'b1;
                r_dec       <= w_dec;
                r_pc        <= inst_pc;
                r_pred_jump <= inst_pred_jump;
                r_rs1_val   <= w_use_rs1 ? w_rs1_new_val : '0;
                r_rs1_tag   <= w_use_rs1 ? w_rs1_new_tag : '0;
                r_rs2_val   <= w_use_rs2 ? w_rs2_new_val : '0;
                r_rs2_tag   <= w_use_rs2 ? w_rs2_new_tag : '0;
            end else if (w_accept || w_fire) begin
                r_valid <= 1'b0;
            end else if (r_valid) begin
                r_rs1_val <= w_rs1_wake_val;
                r_rs1_tag <= w_rs1_wake_tag;
                r_rs2_val <= w_rs2_wake_val;
                r_rs2_tag <= w_rs2_wake_tag;
            end
        end
    end

    assign issue     = w_fire;
    assign rs_en     = w_fire && !r_dec.is_lsb;
    assign lsb_en    = w_fire && r_dec.is_lsb;
    assign rob_pos   = w_fire ? nxt_rob_pos : '0;
    assign opcode    = r_dec.opcode;
    assign funct3    = r_dec.funct3;
    assign funct7    = r_dec.funct7;
    assign is_store  = r_dec.is_store;
    assign is_ready  = r_dec.is_store;
    assign rd        = r_dec.rd;
    assign pc        = r_pc;
    assign pred_jump = r_pred_jump;
    assign imm       = XLEN'($signed(r_dec.imm));

endmodule
`default_nettype wire
